// File: rtl/dvp_pattern_tx_if.sv
// DVP sensor-side byte bus: frame sync, line valid and one pixel byte per clock.
interface dvp_pattern_tx_if;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  modport master (output vsync, href, d);
  modport slave  (input  vsync, href, d);
endinterface

// File: rtl/dvp_pattern_tx.sv
// Synthetic OV5640-style DVP source emitting RGB565 test patterns, two bytes per pixel.
// Optional DVP_TX_FRAME_MARK_EN: pixel (0,0) of each frame carries frame_cnt.
module dvp_pattern_tx #(
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter int   H_BLANK   = 160,
  parameter int   VSYNC_LEN = 4,
  parameter int   V_BACK    = 16,
  parameter int   V_FRONT   = 4,
  parameter logic VS_POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  dvp_pattern_tx_if.master dvp,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             busy
);
  localparam int LINE = 2*H_ACTIVE + H_BLANK;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  localparam logic [2:0]  S_AFTER_VS = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
  localparam logic [2:0]  S_LAST     = (V_FRONT > 0) ? S_VFRONT : S_ACTIVE;
  localparam logic [15:0] LAST_LINE  = (V_FRONT > 0) ? 16'(V_FRONT - 1) : 16'(V_ACTIVE - 1);
  localparam logic [15:0] LINE_M1    = 16'(LINE - 1);
  localparam logic [15:0] HREF_END   = 16'(2*H_ACTIVE);
  localparam logic [15:0] BAR_M1     = 16'(H_ACTIVE/8 - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, end_line;
  logic [1:0]  pat_q, pat_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] bpx_q, bpx_d;
  logic [15:0] frame_cnt_q, frame_cnt_d, pix;
  logic        vsync_q, vsync_d, href_q, href_d, done_q, done_d, busy_q, busy_d;
  logic [7:0]  byte_q, byte_d;

  function automatic logic [15:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_VSYNC:  end_line = 16'(VSYNC_LEN - 1);
      S_VBACK:  end_line = 16'(V_BACK - 1);
      S_ACTIVE: end_line = 16'(V_ACTIVE - 1);
      default:  end_line = 16'(V_FRONT - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    pat_d   = pat_q;
    if (state_q == S_IDLE) begin
      hcnt_d = '0;
      lcnt_d = '0;
      if (enable) state_d = S_VSYNC;
    end else if (hcnt_q != LINE_M1) begin
      hcnt_d = hcnt_q + 16'd1;
    end else begin
      hcnt_d = '0;
      if (lcnt_q != end_line) begin
        lcnt_d = lcnt_q + 16'd1;
      end else begin
        lcnt_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_AFTER_VS;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = (V_FRONT > 0) ? S_VFRONT : (enable ? S_VSYNC : S_IDLE);
          default:  state_d = enable ? S_VSYNC : S_IDLE;
        endcase
      end
    end
    if (state_d == S_VSYNC && state_q != S_VSYNC) pat_d = pattern_sel;
  end

  // Outputs are derived from next-state values so they line up with the state register.
  always_comb begin
    done_d      = (state_d == S_LAST) && (lcnt_d == LAST_LINE) && (hcnt_d == LINE_M1);
    frame_cnt_d = frame_cnt_q + {15'd0, done_d};
    vsync_d     = (state_d == S_VSYNC) ? VS_POL : ~VS_POL;
    busy_d      = (state_d != S_IDLE);

    // Bar index advances every H_ACTIVE/8 pixels, avoiding a divider on x.
    bar_d = bar_q;
    bpx_d = bpx_q;
    if (hcnt_d == '0) begin
      bar_d = '0;
      bpx_d = '0;
    end else if (!hcnt_d[0]) begin
      if (bpx_q == BAR_M1) begin
        bar_d = bar_q + 3'd1;
        bpx_d = '0;
      end else begin
        bpx_d = bpx_q + 16'd1;
      end
    end

    case (pat_d)
      2'd0:    pix = bar_rgb(bar_d);
      2'd1:    pix = {hcnt_d[8:4], hcnt_d[8:3], hcnt_d[8:4]};
      2'd2:    pix = (hcnt_d[4] ^ lcnt_d[3]) ? 16'hFFFF : 16'h0000;
      default: pix = {frame_cnt_d[4:0], 6'b0, ~frame_cnt_d[4:0]};
    endcase
`ifdef DVP_TX_FRAME_MARK_EN
    if (state_d == S_ACTIVE && lcnt_d == '0 && hcnt_d[15:1] == '0) pix = frame_cnt_d;
`endif
    href_d = (state_d == S_ACTIVE) && (hcnt_d < HREF_END);
    byte_d = !href_d ? 8'h00 : (hcnt_d[0] ? pix[7:0] : pix[15:8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      pat_q       <= '0;
      bar_q       <= '0;
      bpx_q       <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= ~VS_POL;
      href_q      <= 1'b0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      pat_q       <= pat_d;
      bar_q       <= bar_d;
      bpx_q       <= bpx_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      byte_q      <= byte_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign dvp.vsync  = vsync_q;
  assign dvp.href   = href_q;
  assign dvp.d      = byte_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
endmodule
